// File: rtl/debug_bridge_pkg.sv
// -----------------------------------------------------------------------------
// debug_bridge_pkg
// Shared definitions for the UART debug bridge: host opcodes, the encodings of
// the command FSM and of the dump serializer FSM, and a ceil-div helper used to
// size the debug-vector dump.
// -----------------------------------------------------------------------------
package debug_bridge_pkg;

    // Host command opcodes, accepted only while the bridge is idle
    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_STEP = 8'h02;
    localparam logic [7:0] OP_RUN  = 8'h03;
    localparam logic [7:0] OP_DUMP = 8'h04;

    // Command decode / program load / core control states
    typedef enum logic [2:0] {
        CMD_IDLE      = 3'd0,
        CMD_LOAD_CNT  = 3'd1,
        CMD_LOAD_BYTE = 3'd2,
        CMD_LOAD_WR   = 3'd3,
        CMD_STEP      = 3'd4,
        CMD_RUN       = 3'd5,
        CMD_DUMP      = 3'd6
    } cmd_state_t;

    // Snapshot serializer states
    typedef enum logic [1:0] {
        DMP_IDLE    = 2'd0,
        DMP_SNAP    = 2'd1,
        DMP_SEND    = 2'd2,
        DMP_WAIT_TX = 2'd3
    } dump_state_t;

    // Integer ceiling division, used to turn a bit width into a byte count
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 32'sd1) / den;
    endfunction

endpackage

// File: rtl/debug_bridge_if.sv
// -----------------------------------------------------------------------------
// debug_bridge_if
// Bundles the UART-side and core-side signals of the debug bridge.
//   slave  : the bridge itself (consumes i_*, drives o_*)
//   master : the surrounding UART/core environment
// Signals:
//   i_rx_done/i_data   received byte strobe and byte
//   i_tx_done          transmitter finished the last byte
//   i_halt/i_debug     core halt flag and debug vector
//   o_step             core clock-enable
//   o_mem_write/o_instruction/o_address  program-memory write port
//   o_data_send/o_tx_start               transmitter request
//   o_busy             bridge is not idle
// -----------------------------------------------------------------------------
interface debug_bridge_if #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 8,
    parameter int DBG_W   = 2554
) ();
    logic               i_rx_done;
    logic [7:0]         i_data;
    logic               i_tx_done;
    logic               i_halt;
    logic [DBG_W-1:0]   i_debug;
    logic               o_step;
    logic               o_mem_write;
    logic [INSTR_W-1:0] o_instruction;
    logic [ADDR_W-1:0]  o_address;
    logic [7:0]         o_data_send;
    logic               o_tx_start;
    logic               o_busy;

    modport slave (
        input  i_rx_done, i_data, i_tx_done, i_halt, i_debug,
        output o_step, o_mem_write, o_instruction, o_address,
               o_data_send, o_tx_start, o_busy
    );

    modport master (
        output i_rx_done, i_data, i_tx_done, i_halt, i_debug,
        input  o_step, o_mem_write, o_instruction, o_address,
               o_data_send, o_tx_start, o_busy
    );
endinterface

// File: rtl/dump_serializer.sv
// -----------------------------------------------------------------------------
// dump_serializer
// Captures the core debug vector (zero-padded to whole bytes) and sends it to
// the UART transmitter LSB byte first, one byte per tx_start/tx_done exchange.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           begin a dump (snapshot taken in the following state)
//   debug           core debug vector
//   tx_done         transmitter finished the current byte
//   done            one-cycle pulse after the last byte completed
//   tx_start        one-cycle transmit request
//   data_send       byte being transmitted
// -----------------------------------------------------------------------------
module dump_serializer
    import debug_bridge_pkg::*;
#(
    parameter int DBG_W = 2554
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DBG_W-1:0] debug,
    input  logic             tx_done,
    output logic             done,
    output logic             tx_start,
    output logic [7:0]       data_send
);
    localparam int NB     = ceil_div(DBG_W, 32'sd8);
    localparam int SNAP_W = NB * 8;
    localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;

    dump_state_t         state_r;
    logic [SNAP_W-1:0]   snap_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                tx_start_r;
    logic [7:0]          data_send_r;
    logic                done_r;
    logic [SNAP_W-1:0]   debug_pad_s;
    logic [SNAP_W-1:0]   snap_shift_s;

    assign debug_pad_s  = SNAP_W'(debug);
    assign snap_shift_s = snap_r >> 8;

    // Snapshot / send / wait-for-transmitter sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= DMP_IDLE;
            snap_r      <= '0;
            cnt_r       <= '0;
            tx_start_r  <= 1'b0;
            data_send_r <= 8'h00;
            done_r      <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                DMP_IDLE: begin
                    if (start) begin
                        state_r <= DMP_SNAP;
                    end
                end
                DMP_SNAP: begin
                    // The byte goes out together with its request strobe
                    snap_r      <= debug_pad_s;
                    data_send_r <= debug_pad_s[7:0];
                    tx_start_r  <= 1'b1;
                    cnt_r       <= '0;
                    state_r     <= DMP_SEND;
                end
                DMP_SEND: begin
                    // A tx_done seen here belongs to nothing and is dropped
                    state_r <= DMP_WAIT_TX;
                end
                DMP_WAIT_TX: begin
                    if (tx_done) begin
                        if (cnt_r == CNT_W'(NB - 1)) begin
                            state_r <= DMP_IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            snap_r      <= snap_shift_s;
                            data_send_r <= snap_shift_s[7:0];
                            tx_start_r  <= 1'b1;
                            cnt_r       <= cnt_r + CNT_W'(1);
                            state_r     <= DMP_SEND;
                        end
                    end
                end
                default: begin
                    state_r <= DMP_IDLE;
                end
            endcase
        end
    end

    assign done      = done_r;
    assign tx_start  = tx_start_r;
    assign data_send = data_send_r;

endmodule

// File: rtl/debug_bridge.sv
// -----------------------------------------------------------------------------
// debug_bridge
// UART debug bridge between the host link and the MIPS core. Decodes host
// opcodes, loads program memory word by word, steps or runs the core and
// hands snapshot dumps to dump_serializer.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   debug_bridge_if.slave (UART rx/tx, core control, program memory)
// -----------------------------------------------------------------------------
module debug_bridge
    import debug_bridge_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 8,
    parameter int DBG_W   = 2554
) (
    input  logic              clk,
    input  logic              rst,
    debug_bridge_if.slave     bus
);
    localparam int IB     = INSTR_W / 8;
    localparam int BCNT_W = (IB > 1) ? $clog2(IB) : 1;

    cmd_state_t          state_r;
    logic [BCNT_W-1:0]   byte_cnt_r;
    logic [8:0]          words_left_r;
    logic [INSTR_W-1:0]  instr_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                step_r;
    logic                mem_write_r;
    logic                busy_r;
    logic                dump_start_r;
    logic                dump_done_s;

    // Command decode, program load and step/run control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= CMD_IDLE;
            byte_cnt_r   <= '0;
            words_left_r <= 9'd0;
            instr_r      <= '0;
            addr_r       <= '0;
            step_r       <= 1'b0;
            mem_write_r  <= 1'b0;
            busy_r       <= 1'b0;
            dump_start_r <= 1'b0;
        end else begin
            step_r       <= 1'b0;
            mem_write_r  <= 1'b0;
            dump_start_r <= 1'b0;
            case (state_r)
                CMD_IDLE: begin
                    if (bus.i_rx_done) begin
                        case (bus.i_data)
                            OP_LOAD: begin
                                state_r <= CMD_LOAD_CNT;
                                busy_r  <= 1'b1;
                            end
                            OP_STEP: begin
                                // Serializer enters SNAP as the single step completes
                                state_r      <= CMD_STEP;
                                step_r       <= 1'b1;
                                dump_start_r <= 1'b1;
                                busy_r       <= 1'b1;
                            end
                            OP_RUN: begin
                                state_r <= CMD_RUN;
                                step_r  <= ~bus.i_halt;
                                busy_r  <= 1'b1;
                            end
                            OP_DUMP: begin
                                state_r      <= CMD_DUMP;
                                dump_start_r <= 1'b1;
                                busy_r       <= 1'b1;
                            end
                            default: begin
                                state_r <= CMD_IDLE;
                            end
                        endcase
                    end
                end
                CMD_LOAD_CNT: begin
                    if (bus.i_rx_done) begin
                        // A count of zero stands for 256 words
                        words_left_r <= (bus.i_data == 8'h00) ? 9'd256 : {1'b0, bus.i_data};
                        addr_r       <= '0;
                        byte_cnt_r   <= '0;
                        state_r      <= CMD_LOAD_BYTE;
                    end
                end
                CMD_LOAD_BYTE: begin
                    if (bus.i_rx_done) begin
                        // Bytes arrive LSB first, so each one enters at the top
                        instr_r <= (instr_r >> 8) | (INSTR_W'(bus.i_data) << (INSTR_W - 8));
                        if (byte_cnt_r == BCNT_W'(IB - 1)) begin
                            byte_cnt_r  <= '0;
                            mem_write_r <= 1'b1;
                            state_r     <= CMD_LOAD_WR;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BCNT_W'(1);
                        end
                    end
                end
                CMD_LOAD_WR: begin
                    addr_r       <= addr_r + ADDR_W'(1);
                    words_left_r <= words_left_r - 9'd1;
                    if (words_left_r == 9'd1) begin
                        state_r <= CMD_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= CMD_LOAD_BYTE;
                    end
                end
                CMD_STEP: begin
                    state_r <= CMD_DUMP;
                end
                CMD_RUN: begin
                    if (bus.i_halt) begin
                        dump_start_r <= 1'b1;
                        state_r      <= CMD_DUMP;
                    end else begin
                        step_r <= 1'b1;
                    end
                end
                CMD_DUMP: begin
                    if (dump_done_s) begin
                        state_r <= CMD_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= CMD_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    dump_serializer #(
        .DBG_W (DBG_W)
    ) u_dump (
        .clk       (clk),
        .rst       (rst),
        .start     (dump_start_r),
        .debug     (bus.i_debug),
        .tx_done   (bus.i_tx_done),
        .done      (dump_done_s),
        .tx_start  (bus.o_tx_start),
        .data_send (bus.o_data_send)
    );

    assign bus.o_step        = step_r;
    assign bus.o_mem_write   = mem_write_r;
    assign bus.o_instruction = instr_r;
    assign bus.o_address     = addr_r;
    assign bus.o_busy        = busy_r;

endmodule

// File: tb/tb_debug_bridge.sv
// -----------------------------------------------------------------------------
// tb_debug_bridge
// Directed self-checking bench: a DBG_W=20 bridge for most scenarios and a
// default-parameter bridge for the full 320-byte dump.
// -----------------------------------------------------------------------------
module tb_debug_bridge;
    import debug_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    debug_bridge_if #(.INSTR_W(32), .ADDR_W(8), .DBG_W(20)) bus ();
    debug_bridge_if bus_big ();

    debug_bridge #(.INSTR_W(32), .ADDR_W(8), .DBG_W(20)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    debug_bridge u_big (
        .clk (clk),
        .rst (rst),
        .bus (bus_big)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Event monitors on the small bridge
    int          step_cnt = 0;
    int          wr_cnt   = 0;
    int          tx_cnt   = 0;
    logic [7:0]  wr_addr [0:1023];
    logic [31:0] wr_data [0:1023];
    logic [7:0]  tx_byte [0:1023];

    always @(negedge clk) begin
        if (bus.o_step === 1'b1) step_cnt <= step_cnt + 1;
        if (bus.o_mem_write === 1'b1 && wr_cnt < 1024) begin
            wr_addr[wr_cnt] <= bus.o_address;
            wr_data[wr_cnt] <= bus.o_instruction;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.o_tx_start === 1'b1 && tx_cnt < 1024) begin
            tx_byte[tx_cnt] <= bus.o_data_send;
            tx_cnt <= tx_cnt + 1;
        end
    end

    // Transmitter model: tx_done three cycles after each tx_start
    initial begin
        int tx_wait;
        tx_wait = 0;
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_tx_done = 1'b0;
            if (tx_wait > 0) begin
                tx_wait = tx_wait - 1;
                if (tx_wait == 0) bus.i_tx_done = 1'b1;
            end
            if (bus.o_tx_start === 1'b1) tx_wait = 3;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_done = 1'b1;
        bus.i_data    = b;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (bus.o_busy === 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: o_busy=%b after %0d cycles, required 0", tag, bus.o_busy, budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.i_rx_done = 1'b0; bus.i_data = 8'h00; bus.i_halt = 1'b0; bus.i_debug = 20'h0;
        bus_big.i_rx_done = 1'b0; bus_big.i_data = 8'h00; bus_big.i_halt = 1'b0;
        bus_big.i_tx_done = 1'b0; bus_big.i_debug = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.o_step, bus.o_mem_write, bus.o_tx_start, bus.o_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: step/wr/tx/busy=%b, required 0000",
                     {bus.o_step, bus.o_mem_write, bus.o_tx_start, bus.o_busy});
        end
        n_tests++;
        if (bus.o_instruction !== 32'h0 || bus.o_address !== 8'h0 || bus.o_data_send !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_data: instr=%h addr=%h data=%h, required 0", bus.o_instruction,
                     bus.o_address, bus.o_data_send);
        end
        n_tests++;
        if ({bus_big.o_step, bus_big.o_mem_write, bus_big.o_tx_start, bus_big.o_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_big: step/wr/tx/busy=%b, required 0000",
                     {bus_big.o_step, bus_big.o_mem_write, bus_big.o_tx_start, bus_big.o_busy});
        end
        rst = 1'b1;
    endtask

    task automatic test_load;
        logic [7:0] b [8];
        int base;
        b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        base = wr_cnt;
        send_byte(OP_LOAD);
        send_byte(8'd2);
        for (int i = 0; i < 8; i++) send_byte(b[i]);
        n_tests++;
        if (bus.o_mem_write !== 1'b1 || bus.o_address !== 8'd1 || bus.o_instruction !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_wr_timing: wr=%b addr=%h instr=%h, required 1/01/deadbeef",
                     bus.o_mem_write, bus.o_address, bus.o_instruction);
        end
        @(negedge clk);
        n_tests++;
        if (bus.o_mem_write !== 1'b0 || bus.o_address !== 8'd2) begin
            n_fail++;
            $display("FAIL load_addr_inc: wr=%b addr=%h, required 0/02", bus.o_mem_write, bus.o_address);
        end
        wait_idle("load", 20);
        n_tests++;
        if (wr_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL load_count: %0d writes, required 2", wr_cnt - base);
        end
        n_tests++;
        if (wr_addr[base] !== 8'd0 || wr_data[base] !== 32'h12345678 ||
            wr_addr[base+1] !== 8'd1 || wr_data[base+1] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_words: %h@%h %h@%h, required 12345678@00 deadbeef@01",
                     wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1]);
        end
    endtask

    task automatic test_ignored_opcode;
        int bs, bt, bw, busy_seen;
        bs = step_cnt; bt = tx_cnt; bw = wr_cnt; busy_seen = 0;
        send_byte(8'h7F);
        for (int i = 0; i < 4; i++) begin
            if (bus.o_busy !== 1'b0) busy_seen++;
            @(negedge clk);
        end
        n_tests++;
        if (busy_seen != 0 || step_cnt != bs || tx_cnt != bt || wr_cnt != bw) begin
            n_fail++;
            $display("FAIL bad_opcode: busy_cycles=%0d steps=%0d tx=%0d wr=%0d, required all 0",
                     busy_seen, step_cnt - bs, tx_cnt - bt, wr_cnt - bw);
        end
    endtask

    task automatic test_step;
        int bs, bt;
        bs = step_cnt; bt = tx_cnt;
        bus.i_debug = 20'h12345;
        send_byte(OP_STEP);
        n_tests++;
        if (bus.o_step !== 1'b1) begin
            n_fail++;
            $display("FAIL step_pulse: o_step=%b, required 1", bus.o_step);
        end
        @(negedge clk);
        // core has now advanced by one step
        bus.i_debug = 20'hABCDE;
        @(negedge clk);
        n_tests++;
        if (bus.o_tx_start !== 1'b1 || bus.o_data_send !== 8'hDE) begin
            n_fail++;
            $display("FAIL step_first_tx: tx_start=%b data=%h, required 1/de", bus.o_tx_start, bus.o_data_send);
        end
        bus.i_debug = 20'h11111;
        wait_idle("step", 100);
        n_tests++;
        if (step_cnt - bs !== 1 || tx_cnt - bt !== 3) begin
            n_fail++;
            $display("FAIL step_counts: steps=%0d tx=%0d, required 1/3", step_cnt - bs, tx_cnt - bt);
        end
        n_tests++;
        if (tx_byte[bt] !== 8'hDE || tx_byte[bt+1] !== 8'hBC || tx_byte[bt+2] !== 8'h0A) begin
            n_fail++;
            $display("FAIL step_bytes: %h %h %h, required de bc 0a", tx_byte[bt], tx_byte[bt+1], tx_byte[bt+2]);
        end
    endtask

    task automatic test_run;
        int bs, bt, bw;
        bs = step_cnt; bt = tx_cnt; bw = wr_cnt;
        bus.i_halt  = 1'b0;
        bus.i_debug = 20'h5A5A5;
        send_byte(OP_RUN);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            case (k)
                2: begin bus.i_rx_done = 1'b1; bus.i_data = OP_LOAD; end
                5: begin bus.i_rx_done = 1'b1; bus.i_data = OP_STEP; end
                9: bus.i_halt = 1'b1;
                default: bus.i_rx_done = 1'b0;
            endcase
        end
        wait_idle("run", 100);
        bus.i_halt = 1'b0;
        n_tests++;
        if (step_cnt - bs !== 10 || wr_cnt - bw !== 0) begin
            n_fail++;
            $display("FAIL run_steps: steps=%0d writes=%0d, required 10/0", step_cnt - bs, wr_cnt - bw);
        end
        n_tests++;
        if (tx_cnt - bt !== 3 || tx_byte[bt] !== 8'hA5 || tx_byte[bt+1] !== 8'hA5 || tx_byte[bt+2] !== 8'h05) begin
            n_fail++;
            $display("FAIL run_dump: n=%0d bytes %h %h %h, required 3: a5 a5 05", tx_cnt - bt,
                     tx_byte[bt], tx_byte[bt+1], tx_byte[bt+2]);
        end
    endtask

    task automatic test_run_halted;
        int bs, bt;
        bs = step_cnt; bt = tx_cnt;
        bus.i_halt = 1'b1;
        send_byte(OP_RUN);
        wait_idle("run_halted", 100);
        bus.i_halt = 1'b0;
        n_tests++;
        if (step_cnt - bs !== 0 || tx_cnt - bt !== 3) begin
            n_fail++;
            $display("FAIL run_halted: steps=%0d tx=%0d, required 0/3", step_cnt - bs, tx_cnt - bt);
        end
    endtask

    task automatic test_load_256;
        int base, errs;
        logic [31:0] exp_w;
        base = wr_cnt; errs = 0;
        send_byte(OP_LOAD);
        send_byte(8'h00);
        for (int w = 0; w < 256; w++)
            for (int i = 0; i < 4; i++) send_byte(8'(4 * w + i));
        wait_idle("load256", 20);
        n_tests++;
        if (wr_cnt - base !== 256 || bus.o_address !== 8'h00) begin
            n_fail++;
            $display("FAIL load256_count: %0d writes addr=%h, required 256/00", wr_cnt - base, bus.o_address);
        end
        for (int j = 0; j < 256; j++) begin
            exp_w = {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
            if (wr_addr[base+j] !== 8'(j) || wr_data[base+j] !== exp_w) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL load256_content: %0d bad writes, required 0", errs);
        end
        base = wr_cnt;
        send_byte(OP_LOAD);
        send_byte(8'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_idle("load_restart", 20);
        n_tests++;
        if (wr_cnt - base !== 1 || wr_addr[base] !== 8'h00 || wr_data[base] !== 32'h44332211) begin
            n_fail++;
            $display("FAIL load_restart: n=%0d %h@%h, required 1: 44332211@00", wr_cnt - base,
                     wr_data[base], wr_addr[base]);
        end
    endtask

    task automatic test_reset_abort;
        int bw, bt;
        // reset while o_step is high
        send_byte(OP_STEP);
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.o_step !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_step_async: step=%b busy=%b, required 0/0", bus.o_step, bus.o_busy);
        end
        @(negedge clk);
        rst = 1'b1;
        bw = wr_cnt;
        send_byte(OP_LOAD);
        send_byte(8'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.o_step, bus.o_mem_write, bus.o_tx_start, bus.o_busy} !== 4'b0000 ||
            bus.o_instruction !== 32'h0 || bus.o_address !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_abort: ctrl=%b instr=%h addr=%h, required 0",
                     {bus.o_step, bus.o_mem_write, bus.o_tx_start, bus.o_busy}, bus.o_instruction, bus.o_address);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bt = tx_cnt;
        bus.i_debug = 20'h13579;
        send_byte(OP_DUMP);
        wait_idle("dump_after_reset", 100);
        n_tests++;
        if (wr_cnt - bw !== 0 || tx_cnt - bt !== 3 || tx_byte[bt] !== 8'h79 ||
            tx_byte[bt+1] !== 8'h35 || tx_byte[bt+2] !== 8'h01) begin
            n_fail++;
            $display("FAIL dump_after_reset: wr=%0d n=%0d bytes %h %h %h, required 0/3: 79 35 01",
                     wr_cnt - bw, tx_cnt - bt, tx_byte[bt], tx_byte[bt+1], tx_byte[bt+2]);
        end
    endtask

    task automatic test_default_dump;
        int cnt, errs, guard;
        logic [7:0] byte_v, exp_b;
        for (int k = 0; k < 2554; k++) begin
            byte_v = 8'(k / 8);
            bus_big.i_debug[k] = byte_v[k % 8];
        end
        @(negedge clk);
        bus_big.i_rx_done = 1'b1;
        bus_big.i_data    = OP_DUMP;
        @(negedge clk);
        bus_big.i_rx_done = 1'b0;
        cnt = 0; errs = 0; guard = 0;
        while (bus_big.o_busy === 1'b1 && guard < 5000) begin
            if (bus_big.o_tx_start === 1'b1) begin
                // top byte carries only bits 2552..2553 of the vector
                exp_b = (cnt == 319) ? 8'h03 : 8'(cnt);
                if (bus_big.o_data_send !== exp_b) errs++;
                cnt++;
                @(negedge clk);
                bus_big.i_tx_done = 1'b1;
                @(negedge clk);
                bus_big.i_tx_done = 1'b0;
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        n_tests++;
        if (bus_big.o_busy !== 1'b0 || cnt != 320) begin
            n_fail++;
            $display("FAIL big_dump_len: busy=%b bytes=%0d, required 0/320", bus_big.o_busy, cnt);
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL big_dump_bytes: %0d wrong bytes, required 0", errs);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_ignored_opcode();
        test_step();
        test_run();
        test_run_halted();
        test_load_256();
        test_reset_abort();
        test_default_dump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_bridge.md
# debug_bridge

Parametrised successor to the current UART debugger. It sits between the UART receiver/transmitter and the MIPS core. It decodes host command bytes, loads program memory word by word, and drives the core in step or run mode. It returns a byte-serialised snapshot of the core's debug vector, with handshaking on transmitter completion.

## Interface
Parameters:
- INSTR_W, 32, instruction width in bits; must be a multiple of 8.
- ADDR_W, 8, program-memory address width.
- DBG_W, 2554, width of the core debug vector.

Derived constants:
- IB = INSTR_W/8, bytes per instruction.
- NB = ceil(DBG_W/8), dump length in bytes.

Ports:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-low.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- i_rx_done  in  1  one-cycle strobe; i_data valid that cycle.
- i_data  in  8  received byte.
- i_tx_done  in  1  one-cycle strobe; transmitter finished the last byte.
- i_halt  in  1  core has retired its halt instruction.
- i_debug  in  DBG_W  core debug vector.
- o_step  out  1  core clock-enable.
- o_mem_write  out  1  one-cycle program-memory write strobe.
- o_instruction  out  INSTR_W  word to write.
- o_address  out  ADDR_W  write address.
- o_data_send  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle transmit request.
- o_busy  out  1  high in every state except IDLE.

## Operation
Reset values:
- All outputs are 0; state is IDLE.
- Address counter, byte counters and snapshot register are cleared.

Opcodes are accepted in IDLE only:
- 0x01 LOAD: the next byte is count C, the number of words; C=0 means 256. Then C×IB bytes follow, LSB first.
- 0x02 STEP: one core cycle, then dump.
- 0x03 RUN: run until i_halt, then dump.
- 0x04 DUMP: dump without advancing the core.
- Any other byte is ignored; the block stays in IDLE.

States:
- IDLE.
- LOAD_CNT: waits for count.
- LOAD_BYTE: assembles a word into o_instruction, shifting each byte into [INSTR_W-1:INSTR_W-8].
- LOAD_WR: o_mem_write=1 for exactly one cycle. Then o_address increments, wrapping mod 2^ADDR_W. Go to LOAD_BYTE, or to IDLE after the C-th word.
- STEP: o_step=1 for one cycle, then SNAP.
- RUN: o_step=1 each cycle while i_halt=0. On the first cycle i_halt=1, o_step=0 and go to SNAP. If i_halt is already 1 on entry, o_step is never asserted.
- SNAP: capture i_debug, zero-padded to NB×8 bits.
- SEND: o_tx_start=1 for one cycle, with o_data_send = snapshot[7:0].
- WAIT_TX: on i_tx_done, shift the snapshot right 8 bits. Go to SEND, or to IDLE after NB bytes.

Other rules:
- Each LOAD starts at address 0.
- i_rx_done outside IDLE/LOAD_CNT/LOAD_BYTE is ignored and not queued.
- Low rst in any state aborts immediately:
  - a partial word is discarded;
  - o_step, o_mem_write and o_tx_start drop asynchronously.

## Timing
- All outputs are registered.
- Opcode accepted at edge t: the next state is active from t+1.
- STEP:
  - o_step is high during cycle t+1;
  - SNAP is at t+2, capturing the core state after exactly one step;
  - the first o_tx_start is at t+3.
- LOAD, last byte of a word at edge t:
  - o_mem_write, o_address and o_instruction are valid together during cycle t+1;
  - o_address increments at t+2.
- Dump: consecutive o_tx_start pulses are separated by at least one cycle after i_tx_done. An i_tx_done arriving in SEND is ignored.
- Dump length is exactly NB bytes; with the DBG_W default this is 320.
- No output toggles while in IDLE.

## Structure
- Package debug_bridge_pkg holds:
  - the opcode constants OP_LOAD=8'h01, OP_STEP=8'h02, OP_RUN=8'h03, OP_DUMP=8'h04;
  - the state encoding;
  - a ceil-div function for NB.
- Sub-module dump_serializer owns SNAP/SEND/WAIT_TX: snapshot register, byte counter and tx handshake. Its handshake is start in, done out.
- The top FSM covers command decode, load and step/run.
- The new top level instantiates debug_bridge in place of the current debugger.

## Test plan
- LOAD with C=2 and bytes 78 56 34 12 EF BE AD DE:
  - two o_mem_write pulses: addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF;
  - then IDLE with o_busy=0.
- STEP with DBG_W=20 and i_debug=0xABCDE (tx_done returned 3 cycles after each start):
  - exactly one o_step cycle;
  - bytes sent are DE, BC, 0A;
  - exactly 3 o_tx_start pulses.
- RUN with i_halt raised 10 cycles after entry:
  - o_step high for exactly 10 cycles;
  - then a full NB-byte dump.
- LOAD with C=0 and ADDR_W=8:
  - 256 writes, addresses 0..255;
  - a following LOAD restarts at 0.
- rst low after 2 of 4 bytes of a word:
  - no write, all outputs 0;
  - a subsequent DUMP works normally.
- Edge and error cases:
  - byte 0x7F: ignored, o_busy stays 0;
  - bytes received during RUN: ignored, with no write and no extra step.
